// File: rtl/mem_pkg.sv
// Shared definitions for the memory-to-writeback pipeline slice.
// Holds the access-width encodings, the exception vector type and the
// bit position used to report an address-alignment error.
package mem_pkg;

    // Access width encodings on mem_width_in (3 is treated as a word)
    localparam logic [1:0] W_BYTE = 2'd0;
    localparam logic [1:0] W_HALF = 2'd1;
    localparam logic [1:0] W_WORD = 2'd2;

    // Exception vector carried down the pipe
    typedef logic [6:0] exp_vec_t;

    // Bit of the exception vector that flags a misaligned access
    localparam int unsigned EXP_ALE = 3;

    // One-hot mask for the alignment-error bit
    function automatic exp_vec_t ale_mask(input logic ale);
        exp_vec_t m;
        m = 7'd0;
        m[EXP_ALE] = ale;
        return m;
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load alignment.
// Selects the addressed byte/half from the raw cache word, extends it to
// 32 bits (sign or zero), and reports whether the access is misaligned.
// Ports:
//   raw_i     - raw 32-bit cache read word
//   addr_lo_i - access address bits [1:0]
//   width_i   - access width (byte/half/word)
//   signed_i  - 1 = sign-extend, 0 = zero-extend
//   data_o    - aligned, extended load data
//   ale_o     - misaligned access for this width/offset
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] raw_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  width_i,
    input  logic        signed_i,
    output logic [31:0] data_o,
    output logic        ale_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word from the raw word
    always_comb begin
        byte_s = 8'd0;
        case (addr_lo_i)
            2'd0:    byte_s = raw_i[7:0];
            2'd1:    byte_s = raw_i[15:8];
            2'd2:    byte_s = raw_i[23:16];
            2'd3:    byte_s = raw_i[31:24];
            default: byte_s = 8'd0;
        endcase
        if (addr_lo_i[1]) begin
            half_s = raw_i[31:16];
        end else begin
            half_s = raw_i[15:0];
        end
    end

    // Extend the selected field and flag misalignment
    always_comb begin
        data_o = raw_i;
        ale_o  = 1'b0;
        case (width_i)
            W_BYTE: begin
                data_o = {{24{signed_i & byte_s[7]}}, byte_s};
                ale_o  = 1'b0;
            end
            W_HALF: begin
                data_o = {{16{signed_i & half_s[15]}}, half_s};
                ale_o  = addr_lo_i[0];
            end
            default: begin
                // Word (encodings 2 and 3): raw word, must be 4-byte aligned
                data_o = raw_i;
                ale_o  = (addr_lo_i != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM2 -> WB pipeline register.
// Aligns/extends load data, raises the alignment exception, forms the
// register-file write request and keeps the LL/SC reservation bit.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   stall, flush         - hold all registers / insert a bubble (flush wins)
//   in_valid ... cache_badv_in - instruction leaving the memory pipe
//   llbit_clr            - drop the reservation (acts even while stalled)
//   wb_*                 - registered writeback/exception request
//   llbit                - current reservation
module mem_wb_stage
    import mem_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic        mem_en_in,
    input  logic        mem_write_in,
    input  logic        is_atom_in,
    input  logic [1:0]  mem_width_in,
    input  logic        signed_ext_in,
    input  logic [1:0]  addr_lo_in,
    input  logic [4:0]  mem_rd_in,
    input  logic [31:0] mem_data_in,
    input  logic [31:0] alu_data_in,
    input  logic [6:0]  mem_exp_in,
    input  logic [31:0] cache_badv_in,
    input  logic        llbit_clr,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [6:0]  wb_exp,
    output logic [31:0] wb_badv,
    output logic        llbit
);

    logic [31:0] align_data_s;
    logic        ale_s;

    logic        valid_d, valid_q;
    logic        we_d, we_q;
    logic [4:0]  rd_d, rd_q;
    logic [31:0] data_d, data_q;
    exp_vec_t    exp_d, exp_q;
    logic [31:0] badv_d, badv_q;
    logic        llbit_d, llbit_q;

    logic        is_load_s, is_sc_s, is_ll_s, commit_s;

    load_align u_load_align (
        .raw_i     (mem_data_in),
        .addr_lo_i (addr_lo_in),
        .width_i   (mem_width_in),
        .signed_i  (signed_ext_in),
        .data_o    (align_data_s),
        .ale_o     (ale_s)
    );

    // Next-state for the writeback slot and the reservation bit
    always_comb begin
        is_load_s = mem_en_in & ~mem_write_in;
        is_sc_s   = mem_en_in & mem_write_in & is_atom_in;
        is_ll_s   = is_load_s & is_atom_in;

        valid_d = in_valid;
        rd_d    = mem_rd_in;
        // Alignment only matters for a real memory access
        exp_d   = mem_exp_in | ale_mask(in_valid & mem_en_in & ale_s);
        if (mem_exp_in != 7'd0) begin
            badv_d = cache_badv_in;
        end else begin
            badv_d = 32'd0;
        end

        // Plain stores are the only valid, exception-free case that never writes
        we_d = in_valid & (mem_rd_in != 5'd0) & (exp_d == 7'd0)
             & (is_load_s | is_sc_s | ~mem_en_in);

        if (!mem_en_in) begin
            data_d = alu_data_in;
        end else if (is_load_s) begin
            data_d = align_data_s;
        end else if (is_sc_s) begin
            // SC reports success from the reservation as it stands this cycle
            data_d = {31'd0, llbit_q};
        end else begin
            data_d = alu_data_in;
        end

        commit_s = in_valid & (exp_d == 7'd0) & ~stall & ~flush;

        if (llbit_clr) begin
            llbit_d = 1'b0;
        end else if (commit_s & is_ll_s) begin
            llbit_d = 1'b1;
        end else if (commit_s & is_sc_s) begin
            llbit_d = 1'b0;
        end else begin
            llbit_d = llbit_q;
        end
    end

    // Writeback slot register: flush clears, stall holds
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            exp_q   <= 7'd0;
            badv_q  <= 32'd0;
        end else if (flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            exp_q   <= 7'd0;
            badv_q  <= 32'd0;
        end else if (!stall) begin
            valid_q <= valid_d;
            we_q    <= we_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            exp_q   <= exp_d;
            badv_q  <= badv_d;
        end
    end

    // Reservation bit: updates every cycle so llbit_clr works under stall
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            llbit_q <= 1'b0;
        end else begin
            llbit_q <= llbit_d;
        end
    end

    assign wb_valid = valid_q;
    assign wb_we    = we_q;
    assign wb_rd    = rd_q;
    assign wb_data  = data_q;
    assign wb_exp   = exp_q;
    assign wb_badv  = badv_q;
    assign llbit    = llbit_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rstn, stall, flush, in_valid, mem_en_in, mem_write_in, is_atom_in;
    logic [1:0]  mem_width_in, addr_lo_in;
    logic        signed_ext_in, llbit_clr;
    logic [4:0]  mem_rd_in;
    logic [31:0] mem_data_in, alu_data_in, cache_badv_in;
    logic [6:0]  mem_exp_in;
    logic        wb_valid, wb_we, llbit;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_badv;
    logic [6:0]  wb_exp;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic        m_valid, m_we, m_llbit;
    logic [4:0]  m_rd;
    logic [31:0] m_data, m_badv;
    logic [6:0]  m_exp;

    mem_wb_stage dut (
        .clk(clk), .rstn(rstn), .stall(stall), .flush(flush),
        .in_valid(in_valid), .mem_en_in(mem_en_in), .mem_write_in(mem_write_in),
        .is_atom_in(is_atom_in), .mem_width_in(mem_width_in),
        .signed_ext_in(signed_ext_in), .addr_lo_in(addr_lo_in),
        .mem_rd_in(mem_rd_in), .mem_data_in(mem_data_in), .alu_data_in(alu_data_in),
        .mem_exp_in(mem_exp_in), .cache_badv_in(cache_badv_in), .llbit_clr(llbit_clr),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_exp(wb_exp), .wb_badv(wb_badv), .llbit(llbit)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, {31'd0, wb_valid}, {31'd0, m_valid});
        chk({tag, ".we"},    {31'd0, wb_we},    {31'd0, m_we});
        chk({tag, ".rd"},    {27'd0, wb_rd},    {27'd0, m_rd});
        chk({tag, ".data"},  wb_data,           m_data);
        chk({tag, ".exp"},   {25'd0, wb_exp},   {25'd0, m_exp});
        chk({tag, ".badv"},  wb_badv,           m_badv);
        chk({tag, ".llbit"}, {31'd0, llbit},    {31'd0, m_llbit});
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0;
        m_exp = 7'd0; m_badv = 32'd0; m_llbit = 1'b0;
    endtask

    // Load result by plain shifting/masking of the raw word
    function automatic logic [31:0] ref_load(input logic [31:0] raw, input logic [1:0] w,
                                             input logic [1:0] lo, input logic sx);
        logic [31:0] v;
        int sh;
        if (w == 2'd0) begin
            sh = 8 * int'(lo);
            v = (raw >> sh) & 32'h0000_00FF;
            if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (w == 2'd1) begin
            sh = (lo >= 2'd2) ? 16 : 0;
            v = (raw >> sh) & 32'h0000_FFFF;
            if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    // Advance one clock: predict from current inputs, then compare after the edge
    task automatic cycle(input string tag);
        logic        n_valid, n_we, n_ll, misal, is_ld, is_sc, is_ll, ok;
        logic [4:0]  n_rd;
        logic [31:0] n_data, n_badv;
        logic [6:0]  n_exp;
        is_ld = mem_en_in && !mem_write_in;
        is_sc = mem_en_in && mem_write_in && is_atom_in;
        is_ll = is_ld && is_atom_in;
        misal = 1'b0;
        if (mem_width_in == 2'd1) misal = (addr_lo_in % 2) != 0;
        else if (mem_width_in >= 2'd2) misal = addr_lo_in != 2'd0;
        n_exp = mem_exp_in;
        if (in_valid && mem_en_in && misal) n_exp = n_exp | (7'd1 << EXP_ALE);
        n_badv = (mem_exp_in != 7'd0) ? cache_badv_in : 32'd0;
        n_valid = in_valid;
        n_rd = mem_rd_in;
        n_we = in_valid && mem_rd_in != 5'd0 && n_exp == 7'd0 && (is_ld || is_sc || !mem_en_in);
        if (is_ld) n_data = ref_load(mem_data_in, mem_width_in, addr_lo_in, signed_ext_in);
        else if (is_sc) n_data = {31'd0, m_llbit};
        else n_data = alu_data_in;
        ok = in_valid && n_exp == 7'd0 && !stall && !flush;
        n_ll = m_llbit;
        if (llbit_clr) n_ll = 1'b0;
        else if (ok && is_ll) n_ll = 1'b1;
        else if (ok && is_sc) n_ll = 1'b0;
        @(posedge clk);
        #1;
        m_llbit = n_ll;
        if (flush) begin
            m_valid = 1'b0; m_we = 1'b0; m_rd = 5'd0; m_data = 32'd0; m_exp = 7'd0; m_badv = 32'd0;
        end else if (!stall) begin
            m_valid = n_valid; m_we = n_we; m_rd = n_rd; m_data = n_data; m_exp = n_exp; m_badv = n_badv;
        end
        check_all(tag);
    endtask

    task automatic op(input logic v, input logic en, input logic wr, input logic atom,
                      input logic [1:0] w, input logic sx, input logic [1:0] lo,
                      input logic [4:0] rd, input logic [31:0] raw, input logic [31:0] alu,
                      input logic [6:0] ex);
        in_valid = v; mem_en_in = en; mem_write_in = wr; is_atom_in = atom;
        mem_width_in = w; signed_ext_in = sx; addr_lo_in = lo; mem_rd_in = rd;
        mem_data_in = raw; alu_data_in = alu; mem_exp_in = ex;
        cache_badv_in = 32'hBAD0_0000 | {30'd0, lo};
    endtask

    initial begin
        logic [31:0] held;
        rstn = 1'b0; stall = 1'b0; flush = 1'b0; llbit_clr = 1'b0;
        op(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 7'd0);
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rstn = 1'b1;

        // Byte loads
        op(1'b1, 1'b1, 1'b0, 1'b0, W_BYTE, 1'b1, 2'd2, 5'd3, 32'h80FF7F01, 32'd0, 7'd0);
        cycle("sbyte");
        chk("sbyte_const", wb_data, 32'hFFFF_FFFF);
        op(1'b1, 1'b1, 1'b0, 1'b0, W_BYTE, 1'b0, 2'd3, 5'd3, 32'h80FF7F01, 32'd0, 7'd0);
        cycle("ubyte");
        chk("ubyte_const", wb_data, 32'h0000_0080);
        // Misaligned half, aligned word
        op(1'b1, 1'b1, 1'b0, 1'b0, W_HALF, 1'b1, 2'd1, 5'd4, 32'h1234_5678, 32'd0, 7'd0);
        cycle("half_ale");
        chk("half_ale_bit", {25'd0, wb_exp}, 32'd1 << EXP_ALE);
        chk("half_ale_we", {31'd0, wb_we}, 32'd0);
        op(1'b1, 1'b1, 1'b0, 1'b0, W_WORD, 1'b0, 2'd0, 5'd4, 32'h1234_5678, 32'd0, 7'd0);
        cycle("word");
        chk("word_const", wb_data, 32'h1234_5678);

        // LL then SC, then SC without reservation
        op(1'b1, 1'b1, 1'b0, 1'b1, W_WORD, 1'b0, 2'd0, 5'd5, 32'hCAFE_F00D, 32'd0, 7'd0);
        cycle("ll");
        chk("ll_set", {31'd0, llbit}, 32'd1);
        op(1'b1, 1'b1, 1'b1, 1'b1, W_WORD, 1'b0, 2'd0, 5'd6, 32'd0, 32'h5555_5555, 7'd0);
        cycle("sc_ok");
        chk("sc_ok_data", wb_data, 32'd1);
        chk("sc_ok_clr", {31'd0, llbit}, 32'd0);
        cycle("sc_fail");
        chk("sc_fail_data", wb_data, 32'd0);

        // Stall with changing inputs
        op(1'b1, 1'b0, 1'b0, 1'b0, W_WORD, 1'b0, 2'd0, 5'd7, 32'd0, 32'hA5A5_0001, 7'd0);
        cycle("pre_stall");
        held = wb_data;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            op(1'b1, 1'b0, 1'b0, 1'b0, W_WORD, 1'b0, 2'd0, 5'(8 + i), 32'd0, 32'h1111_0000 + i, 7'd0);
            cycle("stall");
            chk("stall_frozen", wb_data, 32'hA5A5_0001);
        end
        flush = 1'b1;
        cycle("flush_stall");
        chk("flush_valid", {31'd0, wb_valid}, 32'd0);
        stall = 1'b0; flush = 1'b0;

        // llbit_clr together with LL commit
        llbit_clr = 1'b1;
        op(1'b1, 1'b1, 1'b0, 1'b1, W_WORD, 1'b0, 2'd0, 5'd9, 32'h0000_0042, 32'd0, 7'd0);
        cycle("ll_clr");
        chk("ll_clr_bit", {31'd0, llbit}, 32'd0);
        llbit_clr = 1'b0;

        // rd = 0 load and plain store
        op(1'b1, 1'b1, 1'b0, 1'b0, W_WORD, 1'b0, 2'd0, 5'd0, 32'h0BAD_CAFE, 32'd0, 7'd0);
        cycle("rd0");
        op(1'b1, 1'b1, 1'b1, 1'b0, W_WORD, 1'b0, 2'd0, 5'd10, 32'd0, 32'h7777_7777, 7'd0);
        cycle("store");
        chk("store_we", {31'd0, wb_we}, 32'd0);
        chk("store_valid", {31'd0, wb_valid}, 32'd1);

        // Reset asserted mid-cycle during a stall
        op(1'b1, 1'b1, 1'b0, 1'b1, W_WORD, 1'b0, 2'd0, 5'd11, 32'h0000_0099, 32'd0, 7'd0);
        cycle("pre_rst");
        stall = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rstn = 1'b1; stall = 1'b0;

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            op(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
               ($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), $urandom_range(0, 1),
               2'($urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom, $urandom,
               ($urandom_range(0, 7) == 0) ? 7'($urandom_range(1, 127)) : 7'd0);
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            llbit_clr = ($urandom_range(0, 9) == 0);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register between the second memory stage and register writeback. It captures the raw cache word and exception state for the instruction leaving the memory pipe. It aligns and sign/zero-extends load data by width and address offset, flags misaligned accesses, and tracks the LL/SC reservation bit. Its outputs drive the register-file write port and the exception/commit logic.

## Interface
Parameters:
- none; widths are fixed (32-bit data, 5-bit rd, 7-bit exception vector).

Ports:
- clk  in  1  core clock; all state on rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- stall  in  1  global stall, including the cache stall; holds all registers.
- flush  in  1  pipeline flush; inserts a bubble.
- in_valid  in  1  instruction present in memory stage 1.
- mem_en_in  in  1  instruction is a memory access.
- mem_write_in  in  1  store (1) / load (0).
- is_atom_in  in  1  LL (load) or SC (store).
- mem_width_in  in  2  0 = byte, 1 = half, 2 = word, 3 = word.
- signed_ext_in  in  1  sign-extend load result.
- addr_lo_in  in  2  access address bits [1:0].
- mem_rd_in  in  5  destination register.
- mem_data_in  in  32  raw 32-bit cache read word.
- alu_data_in  in  32  non-memory result, passed through when mem_en_in = 0.
- mem_exp_in  in  7  accumulated exception vector.
- cache_badv_in  in  32  faulting address from cache.
- llbit_clr  in  1  clear reservation (ERTN or exception commit).
- wb_valid  out  1  writeback slot valid.
- wb_we  out  1  register write enable.
- wb_rd  out  5  write register index.
- wb_data  out  32  write data.
- wb_exp  out  7  exception vector, including ALE.
- wb_badv  out  32  bad virtual address.
- llbit  out  1  current reservation; memory stage 0 gates SC requests with it.

## Operation
Priority each cycle:
- flush: all outputs cleared.
- else stall: hold all registers.
- else load the computed values.

Alignment and extension (combinational, before the register):
- Byte: select byte addr_lo, extend 8→32.
- Half: select half addr_lo[1], extend 16→32.
- Word: pass the raw word unchanged.
- Extension uses signed_ext_in (1 = sign, 0 = zero).

Misalignment:
- ALE when a half access has addr_lo[0] = 1, or a word access has addr_lo ≠ 0.
- ALE ORs EXP_ALE into wb_exp.
- wb_badv is the incoming cache_badv_in when mem_exp_in ≠ 0; otherwise 0.

Write enable: wb_we = in_valid & (rd ≠ 0) & (wb_exp == 0) & (load, SC, or non-memory).
- Plain stores never write.

Data select:
- Load: aligned data.
- SC: {31'b0, llbit as sampled this cycle}.
- Non-memory: alu_data_in.

llbit next state, in priority order:
- Clear when llbit_clr.
- Else set when an LL commits (in_valid, load, atomic, no exception, not stalled or flushed).
- Else clear when an SC commits.
- Else hold.
- llbit_clr acts even during stall.

## Timing
- Latency: 1 cycle from input to wb_* outputs.
- Reset: every output and llbit is 0.
- Reset mid-stall clears state immediately; no pending instruction survives.
- Simultaneous flush and stall: flush wins.
- Simultaneous llbit_clr and LL commit: cleared.
- SC in the cycle after an LL: sees llbit = 1.

## Structure
Shared package mem_pkg holds:
- Width encodings: W_BYTE, W_HALF, W_WORD.
- Exception-bit index EXP_ALE and the 7-bit vector type.

One combinational sub-module, load_align, takes (raw, addr_lo, width, signed) and produces (data, ale). The top level holds the register, write-enable logic, and llbit; about 150–200 lines total.

## Test plan
- Signed byte load: raw 0x80FF7F01, addr_lo = 2, signed → wb_data 0xFFFFFFFF; unsigned, addr_lo = 3 → 0x00000080.
- Half load at addr_lo = 1 → wb_exp has EXP_ALE set, wb_we = 0. Word load at addr_lo = 0 with raw 0x12345678 → wb_data 0x12345678.
- LL commit then SC on the next cycle → llbit goes 1 then 0, SC wb_data = 1. SC with no prior LL → wb_data = 0.
- stall held for 3 cycles with changing inputs → outputs frozen. flush together with stall → outputs zero on the next edge.
- llbit_clr in the same cycle as an LL commit → llbit stays 0. rstn pulsed low mid-operation → all outputs 0 asynchronously.
- Load to rd = 0, or a plain store → wb_we = 0, wb_valid = 1.
